fetch_miss_queue: RTL
=====================

Name: fetch_miss_queue

Overview:
- Upstream neighbour of the L2 request/insert bus interface.
- Collects instruction-fetch miss line addresses, drops duplicates, and tracks up to ENTRIES outstanding misses.
- Issues one reqBus request per miss and matches returning insBus fills by request tag.
- Delivers each completed line to the instruction cache fill port.

Parameters:
- ENTRIES, 4: outstanding-miss slots; power of two, 2..16; IDXW = log2(ENTRIES).
- REQ_TAG_HI, 0: constant upper (5-IDXW) bits of reqBus_req; the lower IDXW bits are the slot index.
- ISSUE_GAP, 1: minimum idle cycles between consecutive reqBus_en pulses (0..7).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-low (0 = reset).
- miss_en  in  1  fetch miss strobe.
- miss_addr  in  37  missing line address, bits [43:7].
- miss_ready  out  1  a free slot exists.
- reqBus_en  out  1  L2 request valid, one-cycle pulse.
- reqBus_addr  out  37  request line address [43:7].
- reqBus_req  out  5  request tag {REQ_TAG_HI, slot}.
- reqBus_want_excl  out  1  tied 0 (instruction fetch).
- insBus_en  in  1  fill valid.
- insBus_req  in  5  fill tag.
- insBus_dirty  in  1  ignored; must be 0, otherwise stray_err sets.
- insBus_exclusive  in  1  exclusive grant.
- insBus_data  in  512  line data.
- fill_en  out  1  cache write strobe.
- fill_addr  out  37  filled line address.
- fill_data  out  512  filled line data.
- fill_excl  out  1  registered insBus_exclusive.
- stray_err  out  1  sticky error flag.
- busy  out  1  any slot not FREE.

Behaviour:
- Per-slot state: FREE, PEND (allocated, not sent), WAIT (sent, awaiting fill). Each slot also holds a 37-bit address.
- Reset (rst=0, async):
  - All slots FREE; gap counter = 0.
  - All registered outputs 0: reqBus_en, reqBus_addr, reqBus_req, fill_en, fill_addr, fill_data, fill_excl, stray_err.
  - miss_ready forced 0 while rst=0. busy=0.
  - Reset mid-operation discards all PEND/WAIT slots. Later fills carrying their tags are stray.
- miss_ready: combinational; 1 when rst=1 and any slot is FREE (pre-edge state).
- Allocation (cycle t, miss_en=1):
  - miss_addr is compared against every slot in PEND or WAIT, including a slot completing this same cycle.
  - Hit: the miss is merged and dropped; no state change.
  - Else, if miss_ready=1: the lowest-index FREE slot becomes PEND at edge t+1.
  - Else: the miss is ignored; the requester must hold and retry.
  - A slot freed by a fill in cycle t is not reusable until t+1.
- Issue:
  - In cycle t, when gap counter == 0 and some slot is PEND, select the lowest-index PEND slot.
  - At edge t+1, registers load: reqBus_en=1, reqBus_addr=slot address, reqBus_req={REQ_TAG_HI, idx}. The slot becomes WAIT.
  - reqBus_en is high for exactly one cycle.
  - Gap counter loads ISSUE_GAP on each issue and decrements to 0.
  - Minimum miss-to-request latency: miss_en at t gives PEND at t+1 and reqBus_en during t+2.
- Fill (cycle t, insBus_en=1):
  - Match: insBus_req[4:IDXW]==REQ_TAG_HI and slot insBus_req[IDXW-1:0] is WAIT.
    - At edge t+1: fill_en=1, fill_addr=slot address, fill_data=insBus_data, fill_excl=insBus_exclusive. Slot becomes FREE.
    - fill_en lasts one cycle.
  - No match, or insBus_dirty=1: no fill_en; stray_err sets and stays set until reset.
  - Fills may return in any order. At most one fill per cycle.
- Simultaneous events: allocation, issue and fill may all occur in one cycle on different slots; there is no priority interaction.
- Issue and fill can never target the same slot in one cycle: issue selects PEND, fill requires WAIT.
- busy: registered OR of (slot != FREE).

Test Plan:
- Reset release, miss_en=1 with addr 0x0000_1234 at cycle 0 -> reqBus_en high at cycle 2 only, reqBus_req=5'd0, want_excl=0. insBus_en with req 0, data pattern A, exclusive=1 -> next cycle fill_en=1, fill_addr=0x0000_1234, fill_data=A, fill_excl=1. busy returns to 0.
- Same address missed on 3 consecutive cycles -> exactly one reqBus_en; slot 1 stays FREE.
- Four distinct misses back-to-back with ISSUE_GAP=1 -> reqBus_req 0,1,2,3 on cycles 2,4,6,8; miss_ready=0 after the 4th allocation; a 5th distinct miss is ignored; miss_ready=1 the cycle after the first fill.
- Fills returned in order 2,0,3,1 -> fill_addr matches each slot's address; each slot is reusable next cycle (new miss allocates lowest free index).
- insBus_en with req=5'd9 (tag_hi mismatch), then a fill to a FREE slot, then insBus_dirty=1 -> no fill_en in any case; stray_err=1 and it remains 1.
- rst driven low with 2 slots WAIT -> all outputs 0 asynchronously; after release, fill with tag 0 -> stray_err=1, no fill_en.

Source files
------------

// File: rtl/fetch_miss_queue.sv
// fetch_miss_queue: collects instruction-fetch misses, drops duplicates,
// issues one L2 request per outstanding line and forwards matching fills
// to the instruction cache fill port.

package fetch_miss_queue_pkg;
    localparam int unsigned ADDR_W = 37;
    localparam int unsigned TAG_W  = 5;
    localparam int unsigned DATA_W = 512;
    localparam int unsigned GAP_W  = 3;

    // FREE: unused, PEND: allocated but not yet requested, WAIT: requested, awaiting fill
    typedef enum logic [1:0] {
        S_FREE = 2'd0,
        S_PEND = 2'd1,
        S_WAIT = 2'd2
    } slot_state_e;
endpackage

module fetch_miss_queue
    import fetch_miss_queue_pkg::*;
#(
    parameter int unsigned ENTRIES    = 4,
    parameter int unsigned REQ_TAG_HI = 0,
    parameter int unsigned ISSUE_GAP  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_en,
    input  logic [ADDR_W-1:0] miss_addr,
    output logic              miss_ready,
    output logic              reqBus_en,
    output logic [ADDR_W-1:0] reqBus_addr,
    output logic [TAG_W-1:0]  reqBus_req,
    output logic              reqBus_want_excl,
    input  logic              insBus_en,
    input  logic [TAG_W-1:0]  insBus_req,
    input  logic              insBus_dirty,
    input  logic              insBus_exclusive,
    input  logic [DATA_W-1:0] insBus_data,
    output logic              fill_en,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [DATA_W-1:0] fill_data,
    output logic              fill_excl,
    output logic              stray_err,
    output logic              busy
);

    localparam int unsigned IDXW  = $clog2(ENTRIES);
    localparam int unsigned TAGHW = TAG_W - IDXW;

    localparam logic [TAGHW-1:0] TAG_HI   = TAGHW'(REQ_TAG_HI);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(ISSUE_GAP);

    slot_state_e       state_q [ENTRIES];
    slot_state_e       state_d [ENTRIES];
    logic [ADDR_W-1:0] addr_q  [ENTRIES];
    logic [GAP_W-1:0]  gap_q;

    logic             hit;
    logic             free_found;
    logic             pend_found;
    logic [IDXW-1:0]  free_idx;
    logic [IDXW-1:0]  pend_idx;
    logic [IDXW-1:0]  fill_idx;
    logic [TAGHW-1:0] fill_tag_hi;
    logic             alloc;
    logic             issue;
    logic             fill_hit;
    logic             stray;
    logic             busy_d;

    assign reqBus_want_excl = 1'b0;

    // Fill tag split into constant upper field and slot index
    assign fill_idx    = insBus_req[IDXW-1:0];
    assign fill_tag_hi = insBus_req[TAG_W-1:IDXW];

    // Free-slot availability is forced low while reset is asserted
    assign miss_ready = rst & free_found;

    // Slot search: duplicate detection and lowest-index FREE / PEND selection
    always_comb begin
        hit        = 1'b0;
        free_found = 1'b0;
        pend_found = 1'b0;
        free_idx   = '0;
        pend_idx   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if ((state_q[i] != S_FREE) && (addr_q[i] == miss_addr)) begin
                hit = 1'b1;
            end
            if (state_q[i] == S_FREE) begin
                free_found = 1'b1;
                free_idx   = IDXW'(i);
            end
            if (state_q[i] == S_PEND) begin
                pend_found = 1'b1;
                pend_idx   = IDXW'(i);
            end
        end
    end

    // Per-cycle events; a slot completing this cycle still counts as a hit
    always_comb begin
        alloc    = miss_en & ~hit & free_found;
        issue    = (gap_q == '0) & pend_found;
        fill_hit = insBus_en & ~insBus_dirty & (fill_tag_hi == TAG_HI)
                 & (state_q[fill_idx] == S_WAIT);
        stray    = insBus_en & ~fill_hit;
    end

    // Slot next-state: allocation, issue and fill always target distinct slots
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            state_d[i] = state_q[i];
        end
        if (alloc) begin
            state_d[free_idx] = S_PEND;
        end
        if (issue) begin
            state_d[pend_idx] = S_WAIT;
        end
        if (fill_hit) begin
            state_d[fill_idx] = S_FREE;
        end
        busy_d = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (state_d[i] != S_FREE) begin
                busy_d = 1'b1;
            end
        end
    end

    // Slot state register and line address storage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                state_q[i] <= S_FREE;
                addr_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                state_q[i] <= state_d[i];
            end
            if (alloc) begin
                addr_q[free_idx] <= miss_addr;
            end
        end
    end

    // Issue spacing counter: reloads on each request, counts down to zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gap_q <= '0;
        end else if (issue) begin
            gap_q <= GAP_LOAD;
        end else if (gap_q != '0) begin
            gap_q <= gap_q - GAP_W'(1);
        end
    end

    // L2 request port: one-cycle pulse carrying the selected slot
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reqBus_en   <= 1'b0;
            reqBus_addr <= '0;
            reqBus_req  <= '0;
        end else begin
            reqBus_en <= issue;
            if (issue) begin
                reqBus_addr <= addr_q[pend_idx];
                reqBus_req  <= {TAG_HI, pend_idx};
            end
        end
    end

    // Cache fill port, sticky stray-fill error and busy status
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fill_en   <= 1'b0;
            fill_addr <= '0;
            fill_data <= '0;
            fill_excl <= 1'b0;
            stray_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            fill_en <= fill_hit;
            if (fill_hit) begin
                fill_addr <= addr_q[fill_idx];
                fill_data <= insBus_data;
                fill_excl <= insBus_exclusive;
            end
            stray_err <= stray_err | stray;
            busy      <= busy_d;
        end
    end

endmodule
